// File: rtl/full_subtractor_core.sv
// Registered WIDTH-bit subtractor: difference = (a - b - bin) mod 2^WIDTH with unsigned borrow.
// Two cascaded ripple chains of 1-bit full-subtractor cells feed a single register stage.
module full_subtractor_core #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             out_valid
);

  logic [WIDTH-1:0] d_ab;
  logic [WIDTH-1:0] difference_next;
  logic             borrow_next;

  // One full-subtractor cell: {borrow_out, diff}
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic z);
    return {(~x & y) | (~x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Chain one computes a - b, chain two subtracts bin from that; either borrow-out means a < b + bin
  always_comb begin
    logic       bo_ab;
    logic       bo_bin;
    logic [1:0] cell_ab;
    logic [1:0] cell_bin;
    bo_ab           = 1'b0;
    bo_bin          = 1'b0;
    cell_ab         = 2'b00;
    cell_bin        = 2'b00;
    d_ab            = '0;
    difference_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cell_ab            = fs_cell(a[i], b[i], bo_ab);
      d_ab[i]            = cell_ab[0];
      bo_ab              = cell_ab[1];
      cell_bin           = fs_cell(d_ab[i], bin[i], bo_bin);
      difference_next[i] = cell_bin[0];
      bo_bin             = cell_bin[1];
    end
    borrow_next = bo_ab | bo_bin;
  end

  // Result register; results hold while in_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      difference <= '0;
      borrow     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        difference <= difference_next;
        borrow     <= borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_core.sv
// Directed and random checks of full_subtractor_core at WIDTH=2 and WIDTH=8.
module tb_full_subtractor_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v2;
  logic [1:0] a2, b2, bin2;
  logic [1:0] diff2;
  logic       bo2, ov2;
  logic       v8;
  logic [7:0] a8, b8, bin8;
  logic [7:0] diff8;
  logic       bo8, ov8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_subtractor_core #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .a(a2), .b(b2), .bin(bin2),
    .difference(diff2), .borrow(bo2), .out_valid(ov2)
  );

  full_subtractor_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
    .difference(diff8), .borrow(bo8), .out_valid(ov8)
  );

  task automatic chk2(input string tag, input logic [1:0] ed, input logic eb, input logic ev);
    n_cmp++;
    assert (diff2 === ed) else begin
      n_err++; $error("FAIL %s diff: observed %b expected %b", tag, diff2, ed);
    end
    n_cmp++;
    assert (bo2 === eb) else begin
      n_err++; $error("FAIL %s borrow: observed %b expected %b", tag, bo2, eb);
    end
    n_cmp++;
    assert (ov2 === ev) else begin
      n_err++; $error("FAIL %s out_valid: observed %b expected %b", tag, ov2, ev);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] ed, input logic eb, input logic ev);
    n_cmp++;
    assert (diff8 === ed) else begin
      n_err++; $error("FAIL %s diff: observed %h expected %h", tag, diff8, ed);
    end
    n_cmp++;
    assert (bo8 === eb) else begin
      n_err++; $error("FAIL %s borrow: observed %b expected %b", tag, bo8, eb);
    end
    n_cmp++;
    assert (ov8 === ev) else begin
      n_err++; $error("FAIL %s out_valid: observed %b expected %b", tag, ov8, ev);
    end
  endtask

  // Drive one WIDTH=2 operation on the falling edge; it is captured on the next rising edge
  task automatic step2(input logic v, input logic [1:0] xa, input logic [1:0] xb, input logic [1:0] xc);
    @(negedge clk);
    v2 = v; a2 = xa; b2 = xb; bin2 = xc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ed2;
    logic       eb2;
    logic [7:0] ed8;
    logic       eb8;
    int         ia, ib, ic;

    v2 = 1'b0; a2 = '0; b2 = '0; bin2 = '0;
    v8 = 1'b0; a8 = '0; b8 = '0; bin8 = '0;
    #2 rst = 1'b1;
    #1;
    chk2("reset", 2'b00, 1'b0, 1'b0);
    chk8("reset8", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk2("reset_held", 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Truth-table sweep with bin restricted to 0/1
    step2(1'b1, 2'd0, 2'd0, 2'd0); chk2("tt000", 2'b00, 1'b0, 1'b1);
    step2(1'b1, 2'd0, 2'd0, 2'd1); chk2("tt001", 2'b11, 1'b1, 1'b1);
    step2(1'b1, 2'd0, 2'd1, 2'd0); chk2("tt010", 2'b11, 1'b1, 1'b1);
    step2(1'b1, 2'd0, 2'd1, 2'd1); chk2("tt011", 2'b10, 1'b1, 1'b1);
    step2(1'b1, 2'd1, 2'd0, 2'd0); chk2("tt100", 2'b01, 1'b0, 1'b1);
    step2(1'b1, 2'd1, 2'd0, 2'd1); chk2("tt101", 2'b00, 1'b0, 1'b1);
    step2(1'b1, 2'd1, 2'd1, 2'd0); chk2("tt110", 2'b00, 1'b0, 1'b1);
    step2(1'b1, 2'd1, 2'd1, 2'd1); chk2("tt111", 2'b11, 1'b1, 1'b1);

    // Full-width operands
    step2(1'b1, 2'd3, 2'd3, 2'd3); chk2("fw333", 2'b01, 1'b1, 1'b1);
    step2(1'b1, 2'd3, 2'd1, 2'd1); chk2("fw311", 2'b01, 1'b0, 1'b1);
    step2(1'b1, 2'd0, 2'd3, 2'd3); chk2("fw033", 2'b10, 1'b1, 1'b1);
    step2(1'b1, 2'd2, 2'd2, 2'd0); chk2("zero", 2'b00, 1'b0, 1'b1);

    // Hold while in_valid is low, including undriven operands
    step2(1'b1, 2'd1, 2'd0, 2'd0); chk2("hold_load", 2'b01, 1'b0, 1'b1);
    step2(1'b0, 2'd0, 2'd1, 2'd1); chk2("hold", 2'b01, 1'b0, 1'b0);
    step2(1'b0, 2'bxx, 2'bxx, 2'bxx); chk2("hold_x", 2'b01, 1'b0, 1'b0);

    // Asynchronous reset between edges, then restart
    step2(1'b1, 2'd0, 2'd0, 2'd1); chk2("pre_rst", 2'b11, 1'b1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk2("async_rst", 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk2("rst_edge", 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    v2 = 1'b1; a2 = 2'd1; b2 = 2'd0; bin2 = 2'd1;
    @(posedge clk);
    #1;
    chk2("post_rst", 2'b00, 1'b0, 1'b1);

    // Back-to-back alternation
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        step2(1'b1, 2'd0, 2'd0, 2'd1); chk2("b2b_a", 2'b11, 1'b1, 1'b1);
      end else begin
        step2(1'b1, 2'd1, 2'd0, 2'd0); chk2("b2b_b", 2'b01, 1'b0, 1'b1);
      end
    end

    // Random WIDTH=2 against an integer model
    ed2 = diff2; eb2 = bo2;
    for (int k = 0; k < 1000; k++) begin
      ia = int'($urandom_range(3)); ib = int'($urandom_range(3)); ic = int'($urandom_range(3));
      step2(1'b1, 2'(ia), 2'(ib), 2'(ic));
      ed2 = 2'((ia - ib - ic) & 3);
      eb2 = (ia < ib + ic);
      chk2("rand2", ed2, eb2, 1'b1);
    end
    @(negedge clk);
    v2 = 1'b0;

    // Random WIDTH=8 with random in_valid; model holds last result when idle
    ed8 = 8'h00; eb8 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      logic vv;
      ia = int'($urandom_range(255)); ib = int'($urandom_range(255)); ic = int'($urandom_range(255));
      vv = ($urandom_range(7) != 0);
      @(negedge clk);
      v8 = vv; a8 = 8'(ia); b8 = 8'(ib); bin8 = 8'(ic);
      @(posedge clk);
      #1;
      if (vv) begin
        ed8 = 8'((ia - ib - ic) & 255);
        eb8 = (ia < ib + ic);
      end
      chk8("rand8", ed8, eb8, vv);
    end

    // WIDTH=8 worst-case boundary
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h00; b8 = 8'hff; bin8 = 8'hff;
    @(posedge clk);
    #1;
    chk8("worst8", 8'h02, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_subtractor_core.md
Name: full_subtractor_core

Overview:
- Registered W-bit subtractor. Computes difference = a - b - bin (modulo 2^W) and a borrow flag.
- Default configuration: 2-bit operands, with bin carrying 0 or 1 in normal use.
- Sits in the arithmetic datapath as a leaf block. The result is captured one clock after the inputs are sampled.

Parameters:
- WIDTH, 2, width of a, b, bin and difference (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies a, b, bin this cycle
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- bin  input  WIDTH  borrow-in, unsigned, subtracted as a full WIDTH-bit value
- difference  output  WIDTH  registered (a - b - bin) mod 2^WIDTH
- borrow  output  1  registered; 1 when a < b + bin (true unsigned sum, no truncation)
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset:
  - rst high clears difference, borrow and out_valid to 0 immediately, with no clock needed.
  - The outputs hold 0 while rst stays high.
  - The first capture happens on the first rising clk edge after rst is deasserted.
- Combinational core:
  - Extended result R = {2'b00,a} - {2'b00,b} - {2'b00,bin}, computed at WIDTH+2 bits.
  - difference_next = R[WIDTH-1:0].
  - borrow_next = R[WIDTH+1], the sign bit of the extended result. It equals (a < b + bin).
- Implementation structure:
  - Build as a ripple chain of 1-bit full-subtractor cells, generated per bit.
  - Each cell takes x, y, z and produces d = x^y^z and bo = (~x&y) | (~x&z) | (y&z).
  - Two chains are cascaded: a - b first, then that result minus bin.
  - borrow_next = OR of the two chain borrow-outs. This matches the extended-result definition.
- Register stage:
  - On each rising clk edge with rst low and in_valid high: difference <= difference_next, borrow <= borrow_next, out_valid <= 1.
  - On each rising clk edge with rst low and in_valid low: difference and borrow hold their previous values, out_valid <= 0.
- Latency: exactly 1 cycle from sampled inputs to outputs. Throughput: one operation per cycle, with no backpressure.
- Wrap-around: negative results wrap modulo 2^WIDTH. Example at WIDTH=2: 0-0-1 gives difference 11 with borrow 1.
- Worst-case boundary: a=0, b=max, bin=max gives R = -(2*max). The WIDTH+2-bit intermediate is sufficient and borrow = 1.
- Zero case: a=b and bin=0 gives difference 0 with borrow 0.
- Reset mid-operation: an in-flight result is discarded and out_valid drops to 0 asynchronously. No output changes on the reset release edge itself.
- Unknown or X on inputs while in_valid=0 must not affect the outputs.

Test Plan:
- Truth-table sweep at WIDTH=2, one per cycle with in_valid=1; the response appears on the next cycle:
  - (a,b,bin) = (0,0,0) -> diff 00, borrow 0
  - (0,0,1) -> 11, 1
  - (0,1,0) -> 11, 1
  - (0,1,1) -> 10, 1
  - (1,0,0) -> 01, 0
  - (1,0,1) -> 00, 0
  - (1,1,0) -> 00, 0
  - (1,1,1) -> 11, 1
- Full-width operands: a=3,b=3,bin=3 -> diff 01, borrow 1. a=3,b=1,bin=1 -> diff 01, borrow 0. a=0,b=3,bin=3 -> diff 10, borrow 1.
- Hold behaviour: apply (1,0,0) with in_valid=1, then deassert in_valid and change inputs to (0,1,1) -> diff stays 01, borrow 0, out_valid falls to 0.
- Async reset: with out_valid=1 and diff=11, assert rst between clock edges -> all outputs 0 before the next edge. Release rst and apply (1,0,1) -> the next edge gives diff 00, borrow 0, out_valid 1.
- Back-to-back: alternate (0,0,1) and (1,0,0) every cycle -> the outputs alternate 11/1 and 01/0 with 1-cycle lag, and out_valid stays 1.
- Random: 1000 random operand sets at WIDTH=2 and WIDTH=8 compared against the model (a-b-bin) mod 2^W and (a < b+bin).
